// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Multiplexed 7-segment display controller. An internal prescaler produces
//   one scan tick per digit dwell. Each dwell lights one anode with a PWM
//   window that opens after a short blank guard, so segment changes never
//   happen while an anode is lit. Display data is double-buffered: loads go
//   to a pending copy and reach the shadow copy only when the scan wraps, so
//   a frame never shows a mix of old and new digits.
//
// Ports
//   clk, reset      clock, synchronous active-low reset
//   load            strobe capturing digits/dp_in/digit_en/brightness/blank_lead_en
//   digits          hex nibbles, digit i = digits[4i+3:4i], digit 0 rightmost
//   dp_in           decimal point per digit
//   digit_en        per-digit anode enable
//   blank_lead_en   leading-zero blanking enable
//   brightness      PWM duty level, all-ones = full
//   an, seg, dp     registered pin drives (polarity set by ACTIVE_LOW)
//   scan_idx        digit currently addressed
//   frame_done      one-cycle pulse when the scan wraps to digit 0
module seg7_scan_ctrl #(
    parameter int DIGITS     = 4,
    parameter int CLK_HZ     = 100000000,
    parameter int SCAN_HZ    = 1000,
    parameter int BRIGHT_W   = 4,
    parameter int GUARD      = 4,
    parameter int ACTIVE_LOW = 1,
    localparam int SW        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   digits,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  blank_lead_en,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [SW-1:0]         scan_idx,
    output logic                  frame_done
);

    localparam int TICK = CLK_HZ / SCAN_HZ;
    localparam int PW   = (TICK > 1) ? $clog2(TICK) : 1;
    // Threshold math needs room for (2**BRIGHT_W) * TICK before the shift.
    localparam int TW   = PW + BRIGHT_W + 1;

    localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK - 1);
    localparam logic [SW-1:0]     SCAN_LAST  = SW'(DIGITS - 1);
    localparam logic [TW-1:0]     GUARD_W    = TW'(GUARD);
    localparam logic [TW-1:0]     TICK_W     = TW'(TICK);
    localparam logic [DIGITS-1:0] AN_OFF     = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;
    localparam logic [6:0]        SEG_OFF    = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF     = (ACTIVE_LOW != 0);

    logic [PW-1:0]       presc_q, presc_d;
    logic [SW-1:0]       scan_q, scan_d;
    logic                fd_q;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;

    logic [4*DIGITS-1:0] pd_dig_q, sh_dig_q;
    logic [DIGITS-1:0]   pd_dp_q, sh_dp_q;
    logic [DIGITS-1:0]   pd_en_q, sh_en_q;
    logic                pd_blk_q, sh_blk_q;
    logic [BRIGHT_W-1:0] pd_br_q, sh_br_q;
    logic                pend_valid_q;

    logic                tick, wrap;
    logic [DIGITS-1:0]   lz;
    logic                run;
    logic [3:0]          nib;
    logic [TW-1:0]       thresh, presc_w;
    logic                lit;
    logic [DIGITS-1:0]   an_act;
    logic [6:0]          seg_act;
    logic                dp_act;

    function automatic logic [6:0] dec7(input logic [3:0] n);
        case (n)
            4'h0: dec7 = 7'h3F;  4'h1: dec7 = 7'h06;  4'h2: dec7 = 7'h5B;  4'h3: dec7 = 7'h4F;
            4'h4: dec7 = 7'h66;  4'h5: dec7 = 7'h6D;  4'h6: dec7 = 7'h7D;  4'h7: dec7 = 7'h07;
            4'h8: dec7 = 7'h7F;  4'h9: dec7 = 7'h6F;  4'hA: dec7 = 7'h77;  4'hB: dec7 = 7'h7C;
            4'hC: dec7 = 7'h39;  4'hD: dec7 = 7'h5E;  4'hE: dec7 = 7'h79;  default: dec7 = 7'h71;
        endcase
    endfunction

    assign tick = (presc_q == PRESC_LAST);
    assign wrap = tick && (scan_q == SCAN_LAST);

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        scan_d  = scan_q;
        if (tick) scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
    end

    // Leading-zero blanking runs from the most significant digit down; the
    // chain breaks at the first digit that is non-zero or carries a dp.
    // Digit 0 is never blanked so a zero value still shows '0'.
    always_comb begin
        lz  = '0;
        run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run   = run & sh_blk_q & (sh_dig_q[4*i +: 4] == 4'h0) & ~sh_dp_q[i];
            lz[i] = run;
        end
    end

    always_comb begin
        nib     = sh_dig_q[{scan_q, 2'b00} +: 4];
        thresh  = ((TW'(sh_br_q) + TW'(1)) * TICK_W) >> BRIGHT_W;
        presc_w = TW'(presc_q);
        lit     = sh_en_q[scan_q] && (presc_w >= GUARD_W) && (presc_w < thresh);
        an_act  = '0;
        an_act[scan_q] = lit;
        // Segments follow the addressed digit for the whole dwell; they only
        // change at a dwell boundary, which falls inside the guard window.
        seg_act = lz[scan_q] ? 7'h00 : dec7(nib);
        dp_act  = ~lz[scan_q] & sh_dp_q[scan_q];
        an_d    = (ACTIVE_LOW != 0) ? ~an_act  : an_act;
        seg_d   = (ACTIVE_LOW != 0) ? ~seg_act : seg_act;
        dp_d    = (ACTIVE_LOW != 0) ? ~dp_act  : dp_act;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q      <= '0;
            scan_q       <= '0;
            fd_q         <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            pd_dig_q     <= '0;  sh_dig_q <= '0;
            pd_dp_q      <= '0;  sh_dp_q  <= '0;
            pd_en_q      <= '0;  sh_en_q  <= '0;
            pd_blk_q     <= 1'b0; sh_blk_q <= 1'b0;
            pd_br_q      <= '0;  sh_br_q  <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            scan_q  <= scan_d;
            fd_q    <= wrap;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            if (load) begin
                pd_dig_q <= digits;
                pd_dp_q  <= dp_in;
                pd_en_q  <= digit_en;
                pd_blk_q <= blank_lead_en;
                pd_br_q  <= brightness;
            end
            if (wrap) begin
                // A load landing on the wrap tick is newer than anything pending.
                if (load) begin
                    sh_dig_q <= digits;
                    sh_dp_q  <= dp_in;
                    sh_en_q  <= digit_en;
                    sh_blk_q <= blank_lead_en;
                    sh_br_q  <= brightness;
                end else if (pend_valid_q) begin
                    sh_dig_q <= pd_dig_q;
                    sh_dp_q  <= pd_dp_q;
                    sh_en_q  <= pd_en_q;
                    sh_blk_q <= pd_blk_q;
                    sh_br_q  <= pd_br_q;
                end
                pend_valid_q <= 1'b0;
            end else if (load) begin
                pend_valid_q <= 1'b1;
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign scan_idx   = scan_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with TICK=10, 4 digits, BRIGHT_W=2, GUARD=1,
// active-low pins. A cycle-count reference model predicts every pin each
// clock; a vector table and a few directed sequences check decode,
// blanking, PWM duty and buffer coherency against hand-computed constants.
module tb_seg7_scan_ctrl;

    localparam int DIGITS   = 4;
    localparam int TICK     = 10;
    localparam int FRAME    = TICK * DIGITS;
    localparam int BRIGHT_W = 2;
    localparam int GUARD    = 1;

    typedef struct packed {
        logic [15:0] dig;
        logic [3:0]  dpi;
        logic [3:0]  en;
        logic        blk;
        logic [1:0]  br;
    } cfg_t;

    typedef struct packed {
        cfg_t        c;
        logic [27:0] segs;   // expected pin seg per digit, digit i at [7i+:7]
        logic [3:0]  dpo;    // expected pin dp per digit
        logic [15:0] ons;    // expected lit clocks per dwell, digit i at [4i+:4]
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic        blank_lead_en = 1'b0;
    logic [1:0]  brightness = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  scan_idx;
    logic        frame_done;

    seg7_scan_ctrl #(
        .DIGITS(DIGITS), .CLK_HZ(1000), .SCAN_HZ(100),
        .BRIGHT_W(BRIGHT_W), .GUARD(GUARD), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .load(load), .digits(digits), .dp_in(dp_in),
        .digit_en(digit_en), .blank_lead_en(blank_lead_en), .brightness(brightness),
        .an(an), .seg(seg), .dp(dp), .scan_idx(scan_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // reference model state
    logic [6:0] lut [16];
    int   k = 0;
    cfg_t sh = '0;
    cfg_t pd = '0;
    bit   pv = 1'b0;
    int   last_p = 0;
    int   last_s = 0;

    logic [6:0] cap_seg [4];
    logic       cap_dp  [4];
    int         cap_on  [4];
    int         cap79;

    vec_t vt [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Pins the display should show for shadow config c at presc p, digit s.
    function automatic logic [11:0] exp_pins(cfg_t c, int p, int s);
        bit blk [DIGITS];
        bit above;
        logic [3:0] one_hot;
        logic [6:0] sv;
        logic dv;
        int thr;
        bit lit;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            above = 1'b1;
            for (int j = i + 1; j < DIGITS; j++) if (!blk[j]) above = 1'b0;
            blk[i] = c.blk && (i > 0) && (c.dig[4*i +: 4] == 4'h0) && !c.dpi[i] && above;
        end
        thr = ((int'(c.br) + 1) * TICK) >> BRIGHT_W;
        lit = c.en[s] && (p >= GUARD) && (p < thr);
        one_hot = 4'b0000;
        if (lit) one_hot[s] = 1'b1;
        sv = blk[s] ? 7'h00 : lut[c.dig[4*s +: 4]];
        dv = blk[s] ? 1'b0 : c.dpi[s];
        return {~one_hot, ~sv, ~dv};
    endfunction

    // One clock: predict, advance, compare, then update the model.
    task automatic cyc();
        logic [11:0] e;
        logic efd;
        logic [1:0] esc;
        cfg_t inc;
        bit wrap;
        int p, s;
        inc  = {digits, dp_in, digit_en, blank_lead_en, brightness};
        wrap = 1'b0;
        p    = k % TICK;
        s    = (k / TICK) % DIGITS;
        if (!reset) begin
            e = 12'hFFF; efd = 1'b0; esc = 2'd0;
        end else begin
            e    = exp_pins(sh, p, s);
            wrap = (p == TICK - 1) && (s == DIGITS - 1);
            efd  = wrap;
            esc  = 2'(((k + 1) / TICK) % DIGITS);
        end
        last_p = p;
        last_s = s;
        @(posedge clk);
        #1;
        chk("pins{an,seg,dp,fd,idx}", {17'b0, an, seg, dp, frame_done, scan_idx},
            {17'b0, e, efd, esc});
        if (!reset) begin
            k = 0; sh = '0; pd = '0; pv = 1'b0;
        end else begin
            if (load) pd = inc;
            if (wrap) begin
                if (load) sh = inc;
                else if (pv) sh = pd;
                pv = 1'b0;
            end else if (load) begin
                pv = 1'b1;
            end
            k++;
        end
    endtask

    task automatic set_in(input cfg_t c);
        digits = c.dig; dp_in = c.dpi; digit_en = c.en;
        blank_lead_en = c.blk; brightness = c.br;
    endtask

    task automatic run_to(input int ph);
        int n = 0;
        while ((k % FRAME) != ph && n < 2 * FRAME) begin cyc(); n++; end
        chk("phase_reached", k % FRAME, ph);
    endtask

    task automatic align();
        int n = 0;
        bit ok;
        while (!(pv == 1'b0 && (k % FRAME) == 0) && n < 4 * FRAME) begin cyc(); n++; end
        ok = (pv == 1'b0) && ((k % FRAME) == 0);
        chk("frame_align", ok, 1);
    endtask

    task automatic capture();
        for (int d = 0; d < 4; d++) begin cap_seg[d] = 7'h55; cap_dp[d] = 1'bx; cap_on[d] = 0; end
        cap79 = 0;
        repeat (FRAME) begin
            cyc();
            if (last_p == 5) begin cap_seg[last_s] = seg; cap_dp[last_s] = dp; end
            if (an[last_s] == 1'b0) cap_on[last_s]++;
            if (seg == 7'h79) cap79++;
        end
    endtask

    function automatic vec_t mkv(logic [15:0] d, logic [3:0] dpi, logic [3:0] en, logic blk,
                                 logic [1:0] br, logic [27:0] segs, logic [3:0] dpo,
                                 logic [15:0] ons);
        vec_t v;
        v.c.dig = d; v.c.dpi = dpi; v.c.en = en; v.c.blk = blk; v.c.br = br;
        v.segs = segs; v.dpo = dpo; v.ons = ons;
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [6:0] old2, old3;
        cfg_t c;
        logic [15:0] r;

        lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

        //          digits   dp       en       blk  br    seg d3..d0 (pin)                       dp pins   lit d3..d0
        vt[0] = mkv(16'h1234, 4'h0,   4'hF,    1'b0, 2'd3, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF,    16'h9999);
        vt[1] = mkv(16'h0050, 4'h0,   4'hF,    1'b1, 2'd3, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF,    16'h9999);
        vt[2] = mkv(16'h0000, 4'h0,   4'hF,    1'b1, 2'd3, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF,    16'h9999);
        vt[3] = mkv(16'h0005, 4'b0100,4'hF,    1'b1, 2'd3, {7'h7F, 7'h40, 7'h40, 7'h12}, 4'b1011, 16'h9999);
        vt[4] = mkv(16'h89AB, 4'h0,   4'b1011, 1'b0, 2'd0, {7'h00, 7'h10, 7'h08, 7'h03}, 4'hF,    16'h1011);
        vt[5] = mkv(16'hCDEF, 4'h0,   4'hF,    1'b0, 2'd2, {7'h46, 7'h21, 7'h06, 7'h0E}, 4'hF,    16'h6666);
        vt[6] = mkv(16'h00F0, 4'h0,   4'hF,    1'b1, 2'd1, {7'h7F, 7'h7F, 7'h0E, 7'h40}, 4'hF,    16'h4444);
        vt[7] = mkv(16'h0000, 4'h0,   4'hF,    1'b0, 2'd3, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF,    16'h9999);
        vt[8] = mkv(16'h1234, 4'hF,   4'hF,    1'b1, 2'd3, {7'h79, 7'h24, 7'h30, 7'h19}, 4'h0,    16'h9999);

        // reset held: pins idle throughout
        reset = 1'b0;
        repeat (5) begin
            cyc();
            chk("reset_idle", {an, seg, dp, frame_done, scan_idx}, {4'hF, 7'h7F, 1'b1, 1'b0, 2'd0});
        end
        reset = 1'b1;

        // table vectors
        for (int v = 0; v < 9; v++) begin
            set_in(vt[v].c);
            load = 1'b1; cyc(); load = 1'b0;
            align();
            capture();
            for (int d = 0; d < 4; d++) begin
                chk($sformatf("vec%0d_seg_d%0d", v, d), cap_seg[d], vt[v].segs[7*d +: 7]);
                chk($sformatf("vec%0d_dp_d%0d", v, d), cap_dp[d], vt[v].dpo[d]);
                chk($sformatf("vec%0d_lit_d%0d", v, d), cap_on[d], vt[v].ons[4*d +: 4]);
            end
        end

        // frame_done: one pulse per 40 clocks
        cnt = 0;
        repeat (3 * FRAME) begin cyc(); if (frame_done) cnt++; end
        chk("frame_done_count", cnt, 3);

        // coherency: mid-frame load must not reach digits 2,3 of this frame
        set_in(vt[0].c);
        load = 1'b1; cyc(); load = 1'b0;
        align();
        run_to(15);
        digits = 16'hAAAA;
        load = 1'b1; cyc(); load = 1'b0;
        old2 = 7'h55; old3 = 7'h55;
        for (int n = 0; n < FRAME && (k % FRAME) != 0; n++) begin
            cyc();
            if (last_p == 5 && last_s == 2) old2 = seg;
            if (last_p == 5 && last_s == 3) old3 = seg;
        end
        chk("coh_old_d2", old2, 7'h24);
        chk("coh_old_d3", old3, 7'h79);
        align();
        capture();
        for (int d = 0; d < 4; d++) chk($sformatf("coh_new_d%0d", d), cap_seg[d], 7'h08);

        // load on the wrap tick beats an older pending value
        run_to(5);
        digits = 16'h1111;
        load = 1'b1; cyc(); load = 1'b0;
        run_to(FRAME - 1);
        digits = 16'h2222;
        load = 1'b1; cyc(); load = 1'b0;
        chk("wrap_load_pending_clear", pv, 0);
        capture();
        for (int d = 0; d < 4; d++) chk($sformatf("wrap_new_d%0d", d), cap_seg[d], 7'h24);
        chk("wrap_never_1111", cap79, 0);

        // reset mid-scan at digit 2
        run_to(25);
        reset = 1'b0; cyc();
        chk("mid_reset_pins", {an, seg, dp, frame_done, scan_idx}, {4'hF, 7'h7F, 1'b1, 1'b0, 2'd0});
        reset = 1'b1;
        cnt = 0;
        repeat (FRAME) begin cyc(); if (an != 4'hF) cnt++; end
        chk("dark_after_reset", cnt, 0);

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            r = 16'($urandom);
            c.dig = r >> (4 * $urandom_range(0, 4));
            c.dpi = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            c.en  = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            c.blk = 1'($urandom);
            c.br  = 2'($urandom);
            set_in(c);
            load  = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 399) != 0);
            cyc();
        end
        load = 1'b0;
        reset = 1'b1;
        repeat (FRAME) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
